hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall sequencer for the 5-stage MIPS core. It sits beside the ID-stage decoder and watches ID, EX and MEM state. It drives PC/pipeline-register write enables and flushes for four cases: load-use stalls, taken branches resolved in EX, jumps resolved in ID, and data-memory wait states. It also keeps saturating stall and flush counters for performance analysis.

## Interface
Parameters:
- LU_CYCLES, 1, stall cycles inserted per load-use hazard (1..15)
- MEM_TIMEOUT, 255, consecutive MEM_WAIT cycles before mem_timeout sets
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_rs, id_rt  in  5 each  ID-stage source registers
- id_uses_rs, id_uses_rt  in  1 each  the ID instruction reads rs / rt
- id_jump  in  1  J, JAL or JR decoded in ID (redirect taken in ID)
- ex_dst  in  5  EX-stage destination register
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  branch resolved taken in EX
- mem_req  in  1  MEM stage has an active load/store
- mem_ready  in  1  data memory ack for the current mem_req
- pc_write, ifid_write, idex_write  out  1 each  register write enables
- ifid_flush, idex_flush  out  1 each  insert a bubble into IF/ID, ID/EX
- exmem_hold  out  1  hold EX/MEM and MEM stage
- mem_timeout  out  1  sticky error flag
- stall_count, flush_count  out  CNT_W each  saturating counters

## Operation
- States: RUN, LU_STALL, MEM_WAIT. Internal registers: lu_cnt (4 bits), wait_cnt (8 bits).
- Default outputs: all write enables 1; all flushes, exmem_hold and hold signals 0.
- Conditions are evaluated each cycle in strict priority order:
  1. Freeze (any state, mem_req && !mem_ready):
     - pc_write = ifid_write = idex_write = 0, exmem_hold = 1, no flushes.
     - Next state is MEM_WAIT. wait_cnt increments and saturates.
     - When wait_cnt reaches MEM_TIMEOUT, mem_timeout sets and stays set until rst.
     - lu_cnt is preserved.
  2. Branch (state RUN or LU_STALL, ex_branch_taken):
     - ifid_flush = idex_flush = 1, pc_write = 1.
     - lu_cnt is cleared and next state is RUN, so a pending stall on a wrong-path instruction is aborted.
  3. Load-use (state RUN only):
     - Condition: ex_mem_read && ex_dst != 0 && ((id_uses_rs && id_rs == ex_dst) || (id_uses_rt && id_rt == ex_dst)).
     - Outputs: pc_write = ifid_write = 0, idex_flush = 1.
     - lu_cnt is loaded with LU_CYCLES-1. Next state is LU_STALL if LU_CYCLES > 1, else RUN.
  4. In LU_STALL:
     - Same stall outputs as case 3. lu_cnt decrements; at lu_cnt == 1 the next state is RUN.
     - Load-use detection is suppressed here because EX holds a bubble.
  5. Jump (state RUN, id_jump, no stall active): ifid_flush = 1.
- MEM_WAIT exit when mem_ready rises: wait_cnt clears; next state is LU_STALL if lu_cnt != 0, else RUN. Priority then applies as in the first cycle.
- stall_count increments on every cycle with pc_write == 0.
- flush_count increments on every cycle with ifid_flush == 1.
- Both counters saturate at 2^CNT_W-1; they never wrap.
- ex_dst == 0 never creates a hazard.

## Timing
- Outputs are combinational from the registered state plus current inputs (Mealy), so a hazard takes effect in the same cycle it is detected.
- State, lu_cnt, wait_cnt, counters and mem_timeout update on the rising edge of clk.
- Load-use penalty is exactly LU_CYCLES bubbles. Taken branch costs 2 bubbles. Jump costs 1 bubble.
- Memory wait adds exactly the number of cycles with mem_req && !mem_ready.
- Simultaneous events resolve by the priority above:
  - Freeze beats branch. The frozen EX re-presents ex_branch_taken after release.
  - Branch beats load-use.
  - Load-use beats jump. The jump is seen again after the stall.
- Reset (rst = 1 at an edge, including mid-stall or mid-wait) gives: state RUN, lu_cnt = 0, wait_cnt = 0, counters 0, mem_timeout 0.
- Resulting output values after reset with idle inputs: pc_write = ifid_write = idex_write = 1, flushes 0, exmem_hold 0.

## Test plan
- Reset, idle inputs → pc_write = ifid_write = idex_write = 1, all flushes 0, stall_count = flush_count = 0, mem_timeout = 0.
- ex_mem_read = 1, ex_dst = 8, id_uses_rt = 1, id_rt = 8, LU_CYCLES = 3 → pc_write = 0 and idex_flush = 1 for exactly 3 cycles, then pc_write = 1; stall_count = 3. Repeat with ex_dst = 0 → no stall.
- Load-use hazard (LU_CYCLES = 3) with ex_branch_taken = 1 in the second stall cycle → that cycle ifid_flush = idex_flush = 1 and pc_write = 1; next cycle is RUN with no further stall; flush_count = 1.
- mem_req = 1, mem_ready = 0 for 4 cycles → exmem_hold = 1 and all write enables 0 for 4 cycles; resume on mem_ready = 1. With MEM_TIMEOUT = 2 → mem_timeout = 1 after the 2nd wait cycle and stays set until rst.
- id_jump = 1 concurrent with a load-use hazard → stall takes priority; after the stall, exactly one ifid_flush pulse.
- Drive 2^CNT_W+5 stall cycles with CNT_W = 4 → stall_count holds at 15. Assert rst mid-stall → all counters 0, state RUN next cycle.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard/stall sequencer for the 5-stage MIPS core.
// Handles load-use stalls, EX branch flushes, ID jump flushes and data-memory
// wait states, and keeps saturating stall/flush counters.
module hazard_ctrl #(
    parameter int unsigned LU_CYCLES   = 1,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic [4:0]       ex_dst,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned LU_W   = 4;
    localparam int unsigned WAIT_W = 8;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    state_t             w_eff_state;
    logic [LU_W-1:0]    r_lu_cnt;
    logic [LU_W-1:0]    w_lu_nxt;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [WAIT_W-1:0]  w_wait_nxt;
    logic               r_mem_timeout;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;
    logic               w_freeze;
    logic               w_lu_hazard;
    logic               w_pc_write;
    logic               w_ifid_write;
    logic               w_idex_write;
    logic               w_ifid_flush;
    logic               w_idex_flush;
    logic               w_exmem_hold;

    assign w_freeze    = mem_req && !mem_ready;
    assign w_lu_hazard = ex_mem_read && (ex_dst != 5'd0) &&
                         ((id_uses_rs && (id_rs == ex_dst)) ||
                          (id_uses_rt && (id_rt == ex_dst)));

    // On memory release the cycle behaves as the state that was interrupted
    always_comb begin
        w_eff_state = r_state;
        if (r_state == ST_MEM_WAIT) begin
            w_eff_state = (r_lu_cnt != '0) ? ST_LU_STALL : ST_RUN;
        end
    end

    // Next-state and Mealy outputs, resolved in hazard priority order
    always_comb begin
        w_state_nxt  = r_state;
        w_lu_nxt     = r_lu_cnt;
        w_wait_nxt   = r_wait_cnt;
        w_pc_write   = 1'b1;
        w_ifid_write = 1'b1;
        w_idex_write = 1'b1;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        w_exmem_hold = 1'b0;
        if (w_freeze) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_idex_write = 1'b0;
            w_exmem_hold = 1'b1;
            w_state_nxt  = ST_MEM_WAIT;
            w_wait_nxt   = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + WAIT_W'(1);
        end else begin
            w_wait_nxt  = '0;
            w_state_nxt = ST_RUN;
            if (ex_branch_taken) begin
                w_ifid_flush = 1'b1;
                w_idex_flush = 1'b1;
                w_lu_nxt     = '0;
            end else if (w_eff_state == ST_LU_STALL) begin
                w_pc_write   = 1'b0;
                w_ifid_write = 1'b0;
                w_idex_flush = 1'b1;
                w_lu_nxt     = r_lu_cnt - LU_W'(1);
                w_state_nxt  = (r_lu_cnt == LU_W'(1)) ? ST_RUN : ST_LU_STALL;
            end else if (w_lu_hazard) begin
                w_pc_write   = 1'b0;
                w_ifid_write = 1'b0;
                w_idex_flush = 1'b1;
                w_lu_nxt     = LU_W'(LU_CYCLES - 1);
                w_state_nxt  = (LU_CYCLES > 1) ? ST_LU_STALL : ST_RUN;
            end else if (id_jump) begin
                w_ifid_flush = 1'b1;
            end
        end
    end

    // State, counters and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_lu_cnt      <= '0;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lu_cnt   <= w_lu_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_freeze && (32'(w_wait_nxt) >= MEM_TIMEOUT)) begin
                r_mem_timeout <= 1'b1;
            end
            if (!w_pc_write && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_ifid_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign pc_write    = w_pc_write;
    assign ifid_write  = w_ifid_write;
    assign idex_write  = w_idex_write;
    assign ifid_flush  = w_ifid_flush;
    assign idex_flush  = w_idex_flush;
    assign exmem_hold  = w_exmem_hold;
    assign mem_timeout = r_mem_timeout;
    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed plan scenarios plus randomized traffic, checked
// against a cycle-level behavioural model of the hazard rules.
module tb_hazard_ctrl;

    localparam int unsigned LU     = 3;
    localparam int unsigned TMO    = 2;
    localparam int unsigned CW     = 4;
    localparam int          CNTMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs, id_rt, ex_dst;
    logic          id_uses_rs, id_uses_rt, id_jump;
    logic          ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic          pc_write, ifid_write, idex_write;
    logic          ifid_flush, idex_flush, exmem_hold, mem_timeout;
    logic [CW-1:0] stall_count, flush_count;

    int n_cmp = 0;
    int n_err = 0;

    // model state: bubbles still owed, consecutive wait cycles, counts
    int m_owed, m_wait, m_stalls, m_flushes;
    bit m_to;

    hazard_ctrl #(.LU_CYCLES(LU), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_jump(id_jump), .ex_dst(ex_dst), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_hold(exmem_hold),
        .mem_timeout(mem_timeout), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_dst = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_jump = 1'b0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic set_hazard();
        ex_mem_read = 1'b1; ex_dst = 5'd8; id_uses_rt = 1'b1; id_rt = 5'd8;
    endtask

    // reset applied across one rising edge; returns just after the next falling edge
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_owed = 0; m_wait = 0; m_stalls = 0; m_flushes = 0; m_to = 1'b0;
    endtask

    // evaluate one cycle: compare DUT to the model, then advance the model
    task automatic tick();
        bit haz, frz;
        bit e_pc, e_ifw, e_idw, e_iff, e_idf, e_hold;
        #1;
        check("stall_count", 32'(stall_count), 32'(m_stalls));
        check("flush_count", 32'(flush_count), 32'(m_flushes));
        check("mem_timeout", 32'(mem_timeout), 32'(m_to));
        haz = ex_mem_read && (ex_dst != 0) &&
              ((id_uses_rs && id_rs == ex_dst) || (id_uses_rt && id_rt == ex_dst));
        frz = mem_req && !mem_ready;
        e_pc = 1; e_ifw = 1; e_idw = 1; e_iff = 0; e_idf = 0; e_hold = 0;
        if (frz) begin
            e_pc = 0; e_ifw = 0; e_idw = 0; e_hold = 1;
            m_wait = (m_wait < 255) ? m_wait + 1 : 255;
            if (m_wait >= int'(TMO)) m_to = 1'b1;
        end else begin
            m_wait = 0;
            if (ex_branch_taken) begin
                e_iff = 1; e_idf = 1; m_owed = 0;
            end else if (m_owed > 0) begin
                e_pc = 0; e_ifw = 0; e_idf = 1; m_owed--;
            end else if (haz) begin
                e_pc = 0; e_ifw = 0; e_idf = 1; m_owed = int'(LU) - 1;
            end else if (id_jump) begin
                e_iff = 1;
            end
        end
        check("outputs", 32'({pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_hold}),
              32'({e_pc, e_ifw, e_idw, e_iff, e_idf, e_hold}));
        if (!e_pc && m_stalls < CNTMAX) m_stalls++;
        if (e_iff && m_flushes < CNTMAX) m_flushes++;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        do_reset();

        // reset state with idle inputs
        tick();
        check("rst_stall_count", 32'(stall_count), 32'd0);

        // load-use hazard: exactly LU stall cycles
        do_reset();
        set_hazard();
        repeat (LU) tick();
        check("lu_stall_count", 32'(stall_count), 32'(LU));
        idle_inputs();
        tick();
        check("lu_resume_pc", 32'(pc_write), 32'd1);
        // ex_dst zero never hazards
        ex_mem_read = 1'b1; ex_dst = 5'd0; id_uses_rt = 1'b1; id_rt = 5'd0;
        tick();
        tick();
        check("dst0_stall_count", 32'(stall_count), 32'(LU));

        // branch in the second stall cycle aborts the stall
        do_reset();
        set_hazard();
        tick();
        ex_branch_taken = 1'b1;
        tick();
        idle_inputs();
        tick();
        check("br_flush_count", 32'(flush_count), 32'd1);

        // memory wait for 4 cycles, timeout at 2, sticky until reset
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (4) tick();
        mem_ready = 1'b1;
        tick();
        idle_inputs();
        repeat (3) tick();
        check("timeout_sticky", 32'(mem_timeout), 32'd1);
        do_reset();
        check("timeout_cleared", 32'(mem_timeout), 32'd0);

        // jump with a load-use: stall first, then exactly one flush
        do_reset();
        set_hazard();
        id_jump = 1'b1;
        tick();
        ex_mem_read = 1'b0;
        repeat (LU - 1) tick();
        tick();
        id_jump = 1'b0;
        tick();
        check("jump_flush_count", 32'(flush_count), 32'd1);

        // saturation of stall_count, then reset mid-stall
        do_reset();
        set_hazard();
        repeat ((1 << CW) + 5) tick();
        check("stall_saturated", 32'(stall_count), 32'(CNTMAX));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        m_owed = 0; m_wait = 0; m_stalls = 0; m_flushes = 0; m_to = 1'b0;
        check("rst_mid_stall_cnt", 32'(stall_count), 32'd0);
        tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_dst          = 5'($urandom_range(0, 3));
            id_uses_rs      = 1'($urandom_range(0, 1));
            id_uses_rt      = 1'($urandom_range(0, 1));
            ex_mem_read     = ($urandom_range(0, 9) < 4);
            ex_branch_taken = ($urandom_range(0, 9) == 0);
            id_jump         = ($urandom_range(0, 9) < 2);
            mem_req         = ($urandom_range(0, 9) < 3);
            mem_ready       = 1'($urandom_range(0, 1));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
